// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO definitions: default geometry and Gray/binary helpers
// used by both the write-pointer/full and read-pointer/empty stages.
package fifo_pkg;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int PTR_W  = ADDR_W + 1;

  function automatic logic [PTR_W-1:0] bin_to_gray(input logic [PTR_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_W-1:0] gray_to_bin(input logic [PTR_W-1:0] gray);
    logic [PTR_W-1:0] bin;
    bin[PTR_W-1] = gray[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray_to_bin #(
  parameter int W = fifo_pkg::PTR_W
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = '0;
    bin[W-1] = gray[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/w_ptr_and_full.sv
// Write-domain pointer, full/almost-full, fill level and sticky overflow for
// the dual-clock FIFO; consumes the read pointer already synchronised to wr_clk.
module w_ptr_and_full
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = fifo_pkg::ADDR_W,
  parameter int AF_MARGIN = 2
) (
  input  logic              wr_clk,
  input  logic              wr_rst,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   wq2_rptr,
  output logic              wr_accept,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_ptr,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);

  localparam int W = ADDR_W + 1;
  localparam logic [W-1:0] AF_THRESH = W'((2 ** ADDR_W) - AF_MARGIN);

  logic [W-1:0] wr_bin;
  logic [W-1:0] wr_bin_next;
  logic [W-1:0] gray_next;
  logic [W-1:0] rbin;
  logic [W-1:0] level_next;
  logic [W-1:0] full_ptr;

  // Handshake: wr_en is a request with no ready back-pressure; a word is
  // taken on every edge where wr_accept is high, and wr_accept drops while
  // full or in reset, so the writer must watch full/wr_accept itself.
  assign wr_accept = wr_en & ~full & ~wr_rst;

  assign wr_bin_next = wr_bin + W'(wr_accept);
  assign gray_next   = wr_bin_next ^ (wr_bin_next >> 1);

  gray_to_bin #(.W(W)) u_rptr_bin (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  assign level_next = wr_bin_next - rbin;
  // Full when the writer is exactly one lap ahead: top two Gray bits inverted.
  assign full_ptr   = {~wq2_rptr[W-1:W-2], wq2_rptr[W-3:0]};

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wr_bin      <= '0;
      wr_ptr      <= '0;
      wr_addr     <= '0;
      wr_level    <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_bin      <= wr_bin_next;
      wr_ptr      <= gray_next;
      wr_addr     <= wr_bin_next[ADDR_W-1:0];
      wr_level    <= level_next;
      full        <= (gray_next == full_ptr);
      almost_full <= (level_next >= AF_THRESH);
      overflow    <= overflow | (wr_en & full);
    end
  end

endmodule

// File: tb/tb_w_ptr_and_full.sv
// Directed bench for w_ptr_and_full with hand-computed expectations.
module tb_w_ptr_and_full;

  logic       wr_clk = 1'b0;
  logic       wr_rst;
  logic       wr_en;
  logic [3:0] wq2_rptr;
  logic       wr_accept;
  logic [2:0] wr_addr;
  logic [3:0] wr_ptr;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 wr_clk = ~wr_clk;

  w_ptr_and_full #(.ADDR_W(3), .AF_MARGIN(2)) dut (
    .wr_clk      (wr_clk),
    .wr_rst      (wr_rst),
    .wr_en       (wr_en),
    .wq2_rptr    (wq2_rptr),
    .wr_accept   (wr_accept),
    .wr_addr     (wr_addr),
    .wr_ptr      (wr_ptr),
    .full        (full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .overflow    (overflow)
  );

  function automatic logic [3:0] g(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic edge_step();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic test_reset();
    wr_rst = 1'b1; wr_en = 1'b1; wq2_rptr = 4'b0000;
    #1;
    checks++;
    if (wr_accept !== 1'b0) begin
      errors++; $display("FAIL reset_accept got %b want 0", wr_accept);
    end
    edge_step();
    edge_step();
    checks++;
    if ({wr_addr, wr_ptr, full, almost_full, wr_level, overflow, wr_accept} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs addr=%0d ptr=%b full=%b af=%b lvl=%0d ovf=%b acc=%b want all 0",
               wr_addr, wr_ptr, full, almost_full, wr_level, overflow, wr_accept);
    end
    wr_rst = 1'b0;
    #1;
    checks++;
    if (wr_accept !== 1'b1 || wr_addr !== 3'd0) begin
      errors++; $display("FAIL reset_first_accept acc=%b addr=%0d want 1/0", wr_accept, wr_addr);
    end
  endtask

  task automatic test_fill();
    logic [3:0] exp_ptr [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0111, 4'b0101, 4'b0100, 4'b1100};
    for (int k = 1; k <= 8; k++) begin
      edge_step();
      checks++;
      if (wr_ptr !== exp_ptr[k-1] || wr_addr !== 3'(k) || wr_level !== 4'(k)) begin
        errors++;
        $display("FAIL fill_ptr k=%0d ptr=%b addr=%0d lvl=%0d want %b/%0d/%0d",
                 k, wr_ptr, wr_addr, wr_level, exp_ptr[k-1], 3'(k), k);
      end
      checks++;
      if (almost_full !== (k >= 6) || full !== (k == 8)) begin
        errors++;
        $display("FAIL fill_flags k=%0d af=%b full=%b want %b/%b", k, almost_full, full, k >= 6, k == 8);
      end
    end
  endtask

  task automatic test_overflow();
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (wr_accept !== 1'b0) begin
        errors++; $display("FAIL ovf_accept i=%0d got %b want 0", i, wr_accept);
      end
      edge_step();
      checks++;
      if (wr_ptr !== 4'b1100 || overflow !== 1'b1 || full !== 1'b1) begin
        errors++;
        $display("FAIL ovf_hold i=%0d ptr=%b ovf=%b full=%b want 1100/1/1", i, wr_ptr, overflow, full);
      end
    end
  endtask

  task automatic test_release();
    wr_en = 1'b0; wq2_rptr = 4'b0001;
    edge_step();
    checks++;
    if (full !== 1'b0 || wr_level !== 4'd7 || almost_full !== 1'b1) begin
      errors++; $display("FAIL release full=%b lvl=%0d af=%b want 0/7/1", full, wr_level, almost_full);
    end
    wr_en = 1'b1;
    #1;
    checks++;
    if (wr_accept !== 1'b1) begin
      errors++; $display("FAIL release_accept got %b want 1", wr_accept);
    end
    edge_step();
    wr_en = 1'b0;
    checks++;
    if (wr_ptr !== 4'b1101 || full !== 1'b1 || wr_level !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL refill ptr=%b full=%b lvl=%0d ovf=%b want 1101/1/8/1", wr_ptr, full, wr_level, overflow);
    end
  endtask

  task automatic test_tracking();
    int lvl_bad = 0;
    int full_seen = 0;
    wr_rst = 1'b1; wr_en = 1'b0; wq2_rptr = 4'b0000;
    edge_step();
    wr_rst = 1'b0;
    checks++;
    if (overflow !== 1'b0 || wr_ptr !== 4'b0000) begin
      errors++; $display("FAIL track_reset ovf=%b ptr=%b want 0/0000", overflow, wr_ptr);
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1;
      wq2_rptr = g((i == 0) ? 0 : i - 1);
      edge_step();
      if (full) full_seen++;
      if (wr_level !== ((i == 0) ? 4'd1 : 4'd2)) lvl_bad++;
      if (i == 14) begin
        checks++;
        if (wr_ptr !== 4'b1000) begin
          errors++; $display("FAIL track_ptr15 got %b want 1000", wr_ptr);
        end
      end
      if (i == 15) begin
        checks++;
        if (wr_ptr !== 4'b0000) begin
          errors++; $display("FAIL track_wrap got %b want 0000", wr_ptr);
        end
      end
    end
    wr_en = 1'b0;
    checks++;
    if (full_seen != 0 || lvl_bad != 0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL track_flags full_cycles=%0d bad_level=%0d ovf=%b want 0/0/0", full_seen, lvl_bad, overflow);
    end
    checks++;
    if (wr_ptr !== 4'b0110 || wr_addr !== 3'd4) begin
      errors++; $display("FAIL track_end ptr=%b addr=%0d want 0110/4", wr_ptr, wr_addr);
    end
  endtask

  task automatic test_mid_reset();
    wr_en = 1'b0; wq2_rptr = 4'b0000;
    edge_step();
    checks++;
    if (wr_level !== 4'd4) begin
      errors++; $display("FAIL mid_level got %0d want 4", wr_level);
    end
    wr_rst = 1'b1; wr_en = 1'b1;
    #1;
    checks++;
    if (wr_accept !== 1'b0) begin
      errors++; $display("FAIL mid_rst_accept got %b want 0", wr_accept);
    end
    edge_step();
    checks++;
    if ({wr_addr, wr_ptr, full, almost_full, wr_level, overflow} !== 14'd0) begin
      errors++;
      $display("FAIL mid_rst_outputs addr=%0d ptr=%b full=%b af=%b lvl=%0d ovf=%b want all 0",
               wr_addr, wr_ptr, full, almost_full, wr_level, overflow);
    end
    wr_rst = 1'b0;
    #1;
    checks++;
    if (wr_accept !== 1'b1 || wr_addr !== 3'd0) begin
      errors++; $display("FAIL mid_first_accept acc=%b addr=%0d want 1/0", wr_accept, wr_addr);
    end
    edge_step();
    wr_en = 1'b0;
    checks++;
    if (wr_addr !== 3'd1 || wr_ptr !== 4'b0001 || wr_level !== 4'd1) begin
      errors++; $display("FAIL mid_after addr=%0d ptr=%b lvl=%0d want 1/0001/1", wr_addr, wr_ptr, wr_level);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_tracking();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/w_ptr_and_full.md
Name: w_ptr_and_full

Overview:
Write-domain pointer and full-flag logic for the dual-clock FIFO. It is the upstream counterpart of the read-pointer/empty stage.
- Accepts writer requests and produces the memory write strobe and write address.
- Publishes the Gray-coded write pointer that is synchronised into the read domain.
- Derives full, almost-full, fill level and a sticky overflow flag from the read pointer already synchronised into the write domain.

Parameters:
ADDR_W, 3, memory address width; FIFO depth DEPTH = 2**ADDR_W.
AF_MARGIN, 2, almost_full asserts when level >= DEPTH - AF_MARGIN; legal range 1..DEPTH-1.

Ports:
wr_clk  input  1  write-domain clock; all state updates on the rising edge.
wr_rst  input  1  synchronous, active-high reset, sampled on rising wr_clk.
wr_en  input  1  writer request; one word per cycle while high.
wq2_rptr  input  ADDR_W+1  Gray read pointer, already double-flopped into wr_clk.
wr_accept  output  1  combinational memory write strobe = wr_en & ~full & ~wr_rst.
wr_addr  output  ADDR_W  registered memory write address for the current cycle.
wr_ptr  output  ADDR_W+1  registered Gray write pointer, sent to the read-side synchroniser.
full  output  1  registered; no further writes accepted while high.
almost_full  output  1  registered threshold flag.
wr_level  output  ADDR_W+1  registered fill level, 0..DEPTH, as seen from the write side.
overflow  output  1  sticky error flag.

Behaviour:
- Reset (wr_rst high at an edge):
  - wr_bin, wr_ptr, wr_addr and wr_level go to 0.
  - full, almost_full and overflow go to 0.
  - wr_accept is forced low during reset.
  - Reset mid-operation discards all pointer state on that edge. The read side must be reset in the same window; the two resets are not coordinated here.
- Internal state: binary counter wr_bin of width ADDR_W+1.
  - wr_bin_next = wr_bin + wr_accept, modulo 2**(ADDR_W+1).
  - gray_next = wr_bin_next ^ (wr_bin_next >> 1).
- Each edge (no reset):
  - wr_bin <= wr_bin_next; wr_ptr <= gray_next.
  - wr_addr <= wr_bin_next[ADDR_W-1:0], so wr_addr always equals wr_bin[ADDR_W-1:0].
  - Data presented with wr_accept is written at the current wr_addr, with zero latency to the memory strobe.
- Full detection: full <= (gray_next == {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]}).
  - Full asserts on the same edge as the DEPTH-th outstanding accept, with no bubble.
  - Deassertion lags the reader by the 2-flop synchroniser plus one edge. This is conservative by design.
- Level: rbin = gray_to_bin(wq2_rptr); wr_level <= wr_bin_next - rbin, taken modulo 2**(ADDR_W+1). The result is always 0..DEPTH.
- almost_full <= (wr_bin_next - rbin) >= DEPTH - AF_MARGIN.
- overflow: set on any edge where wr_en=1 and full=1. It clears only on wr_rst. A rejected write leaves the pointers unchanged.
- Simultaneous write and read-pointer advance while full=0 with level DEPTH-1: the write is accepted, and full is computed against the new wq2_rptr. A net level of DEPTH-1 keeps full low.
- Wrap-around: wr_bin rolls over from 2**(ADDR_W+1)-1 to 0 and the Gray code rolls over to 0. The MSB inversion in the full compare handles the lap distinction.
- wq2_rptr is treated as a stable, glitch-free Gray value. No additional synchronisation happens inside this block.

Decomposition:
- Shared package fifo_pkg holds:
  - the default ADDR_W;
  - localparams DEPTH and PTR_W = ADDR_W+1;
  - pure functions bin_to_gray and gray_to_bin, parameterised on PTR_W.
- The read-side stage uses the same package.
- One natural sub-module: gray_to_bin (combinational XOR-prefix converter, width PTR_W). It is instantiated here for rbin and reused by any read-side level logic.
- The 2-flop synchroniser stays a separate block outside this module.

Test Plan:
1. Hold wr_rst=1 for 2 edges with wr_en=1 -> every output is 0, including wr_accept=0. Release reset with wq2_rptr=0 -> first accept at wr_addr=0.
2. Defaults; wq2_rptr=0; wr_en=1 for 8 cycles:
   - wr_ptr sequence is 0001,0011,0010,0110,0111,0101,0100,1100.
   - wr_addr runs 1..7 then 0.
   - almost_full rises after the 6th accept.
   - full=1 and wr_level=8 after the 8th accept.
3. While full, hold wr_en=1 for 3 cycles -> wr_accept=0, wr_ptr stays 1100, overflow=1 and stays high until wr_rst.
4. From full, drive wq2_rptr=0001 -> next edge full=0 and wr_level=7. A single write then gives wr_ptr=1101 and full=1 again.
5. Reader tracks the writer at 1-cycle lag for 20 writes -> full never asserts, wr_ptr wraps through 1000 back to 0000, wr_level stays at most 2, overflow stays 0.
6. At level 4, assert wr_rst for 1 edge with wr_en=1 -> pointers, level and flags are 0 on that edge, and the next accept writes wr_addr=0.
